// File: rtl/growl_io_pkg.sv
// Shared definitions for the growl CPU I/O responder: register offsets,
// STATUS/CTRL bit positions and the timer compare reset value.
package growl_io_pkg;

    // Register offsets within the 8-entry window (adr[2:0])
    localparam logic [2:0] OFF_DATA    = 3'd0;
    localparam logic [2:0] OFF_STATUS  = 3'd1;
    localparam logic [2:0] OFF_CTRL    = 3'd2;
    localparam logic [2:0] OFF_TMR_CNT = 3'd3;
    localparam logic [2:0] OFF_TMR_CMP = 3'd4;

    // STATUS bit positions
    localparam int ST_RX_NONEMPTY = 0;
    localparam int ST_RX_FULL     = 1;
    localparam int ST_TX_BUSY     = 2;
    localparam int ST_RX_OVF      = 3;
    localparam int ST_TMR_MATCH   = 4;
    localparam int ST_TX_OVR      = 5;

    // CTRL bit positions
    localparam int CT_TMR_EN     = 0;
    localparam int CT_IRQ_RX_EN  = 1;
    localparam int CT_IRQ_TMR_EN = 2;

    localparam logic [7:0] TMR_CMP_RST = 8'hFF;

    // Assemble the STATUS byte from its individual flags; bits 7:6 read 0
    function automatic logic [7:0] packStatus(
        input logic rxNonempty,
        input logic rxFull,
        input logic txBusy,
        input logic rxOvf,
        input logic tmrMatch,
        input logic txOvr
    );
        logic [7:0] s;
        s                 = 8'h00;
        s[ST_RX_NONEMPTY] = rxNonempty;
        s[ST_RX_FULL]     = rxFull;
        s[ST_TX_BUSY]     = txBusy;
        s[ST_RX_OVF]      = rxOvf;
        s[ST_TMR_MATCH]   = tmrMatch;
        s[ST_TX_OVR]      = txOvr;
        return s;
    endfunction

endpackage

// File: rtl/io_rx_fifo.sv
// Receive byte FIFO for the I/O responder. DEPTH must be a power of two so
// the read/write pointers wrap naturally. A push while full is accepted only
// when a pop happens in the same cycle; a pop while empty is ignored.
module io_rx_fifo
    import growl_io_pkg::*;
#(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 8,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] head_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             doPush;
    logic             doPop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rdPtr_q];
    assign count_o = count_q;

    assign doPop  = pop_i & ~empty_o;
    assign doPush = push_i & (~full_o | doPop);

    // Next-state for pointers and occupancy
    always_comb begin
        wrPtr_d = wrPtr_q + PTR_W'(doPush);
        rdPtr_d = rdPtr_q + PTR_W'(doPop);
        count_d = count_q + CNT_W'(doPush) - CNT_W'(doPop);
    end

    // Pointer and count registers; reset empties the FIFO
    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    // Storage array; contents need no reset since occupancy governs validity
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/io_bus_responder.sv
// Memory-mapped I/O target on the growl CPU data bus: RX byte FIFO, TX
// holding register, optional 8-bit timer with compare, one level irq.
// Read data is combinational so the CPU captures it in the same cycle.
// Optional timer is built when GROWL_IO_TIMER_EN is defined.
module io_bus_responder
    import growl_io_pkg::*;
#(
    parameter logic [5:0] BASE_ADR = 6'h20,
    parameter int         RX_DEPTH = 4,
    parameter int         PRESCALE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] adr,
    input  logic [7:0] dbus_wdata,
    input  logic       io_re,
    input  logic       io_we,
    output logic [7:0] dbus_rdata,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       irq
);

    localparam int RX_CNT_W = $clog2(RX_DEPTH + 1);

`ifdef GROWL_IO_TIMER_EN
    localparam logic [2:0] CTRL_WMASK = 3'b111;
`else
    localparam logic [2:0] CTRL_WMASK = 3'b010;
`endif

    // Elaboration-time guard against unsupported parameter values
    if (RX_DEPTH < 2 || (RX_DEPTH & (RX_DEPTH - 1)) != 0) begin : g_badDepth
        $error("io_bus_responder: RX_DEPTH must be a power of two >= 2");
    end
    if (PRESCALE < 1) begin : g_badPrescale
        $error("io_bus_responder: PRESCALE must be >= 1");
    end

    logic                selected;
    logic [2:0]          off;
    logic                rdEn;
    logic                wrEn;
    logic                wrData;
    logic                wrStatus;
    logic                wrCtrl;
    logic                popReq;
    logic                popOk;
    logic [7:0]          rxHead;
    logic [RX_CNT_W-1:0] rxCount;
    logic                rxFull;
    logic                rxEmpty;
    logic                rxNonempty;
    logic                rxOvfSet;
    logic                txOvrSet;
    logic                tmrMatch;
    logic [7:0]          tmrCntRd;
    logic [7:0]          tmrCmpRd;

    logic [7:0] txData_q, txData_d;
    logic       txValid_q, txValid_d;
    logic       rxOvf_q, rxOvf_d;
    logic       txOvr_q, txOvr_d;
    logic [2:0] ctrl_q, ctrl_d;
    logic       irq_q, irq_d;

    assign selected = (adr[5:3] == BASE_ADR[5:3]);
    assign off      = adr[2:0];
    assign rdEn     = io_re & selected;
    assign wrEn     = io_we & selected;
    assign wrData   = wrEn & (off == OFF_DATA);
    assign wrStatus = wrEn & (off == OFF_STATUS);
    assign wrCtrl   = wrEn & (off == OFF_CTRL);

    assign popReq     = rdEn & (off == OFF_DATA);
    assign popOk      = popReq & ~rxEmpty;
    assign rxNonempty = (rxCount != '0);
    assign rxOvfSet   = rx_valid & rxFull & ~popOk;
    assign txOvrSet   = wrData & txValid_q;

    io_rx_fifo #(
        .DEPTH (RX_DEPTH),
        .WIDTH (8)
    ) u_rxFifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (rx_valid),
        .pop_i   (popReq),
        .wdata_i (rx_data),
        .head_o  (rxHead),
        .count_o (rxCount),
        .full_o  (rxFull),
        .empty_o (rxEmpty)
    );

`ifdef GROWL_IO_TIMER_EN
    localparam int              PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0] ps_q, ps_d;
    logic [7:0]      tmrCnt_q, tmrCnt_d;
    logic [7:0]      tmrCmp_q, tmrCmp_d;
    logic            tmrMatch_q, tmrMatch_d;
    logic            matchSet;
    logic            wrTmrCnt;
    logic            wrTmrCmp;

    assign wrTmrCnt = wrEn & (off == OFF_TMR_CNT);
    assign wrTmrCmp = wrEn & (off == OFF_TMR_CMP);

    // Timer next-state: a CPU write to the count overrides any tick and
    // restarts the prescaler; a tick at the compare value wraps to zero
    always_comb begin
        ps_d     = ps_q;
        tmrCnt_d = tmrCnt_q;
        tmrCmp_d = tmrCmp_q;
        matchSet = 1'b0;
        if (wrTmrCnt) begin
            tmrCnt_d = dbus_wdata;
            ps_d     = '0;
        end else if (ctrl_q[CT_TMR_EN]) begin
            if (ps_q == PS_LAST) begin
                ps_d = '0;
                if (tmrCnt_q == tmrCmp_q) begin
                    tmrCnt_d = 8'h00;
                    matchSet = 1'b1;
                end else begin
                    tmrCnt_d = tmrCnt_q + 8'd1;
                end
            end else begin
                ps_d = ps_q + PS_W'(1);
            end
        end
        if (wrTmrCmp) begin
            tmrCmp_d = dbus_wdata;
        end
        tmrMatch_d = matchSet | (tmrMatch_q & ~(wrStatus & dbus_wdata[ST_TMR_MATCH]));
    end

    // Timer state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            ps_q       <= '0;
            tmrCnt_q   <= 8'h00;
            tmrCmp_q   <= TMR_CMP_RST;
            tmrMatch_q <= 1'b0;
        end else begin
            ps_q       <= ps_d;
            tmrCnt_q   <= tmrCnt_d;
            tmrCmp_q   <= tmrCmp_d;
            tmrMatch_q <= tmrMatch_d;
        end
    end

    assign tmrMatch = tmrMatch_q;
    assign tmrCntRd = tmrCnt_q;
    assign tmrCmpRd = tmrCmp_q;
`else
    assign tmrMatch = 1'b0;
    assign tmrCntRd = 8'h00;
    assign tmrCmpRd = 8'h00;
`endif

    // Next-state for TX holding register, sticky flags, CTRL and irq.
    // A TX write while busy is dropped even if the handshake completes now.
    always_comb begin
        txData_d  = txData_q;
        txValid_d = txValid_q;
        if (wrData && !txValid_q) begin
            txData_d  = dbus_wdata;
            txValid_d = 1'b1;
        end else if (txValid_q && tx_ready) begin
            txValid_d = 1'b0;
        end
        rxOvf_d = rxOvfSet | (rxOvf_q & ~(wrStatus & dbus_wdata[ST_RX_OVF]));
        txOvr_d = txOvrSet | (txOvr_q & ~(wrStatus & dbus_wdata[ST_TX_OVR]));
        ctrl_d  = wrCtrl ? (dbus_wdata[2:0] & CTRL_WMASK) : ctrl_q;
        irq_d   = (ctrl_q[CT_IRQ_RX_EN] & rxNonempty) | (ctrl_q[CT_IRQ_TMR_EN] & tmrMatch);
    end

    // Control/status registers
    always_ff @(posedge clk) begin
        if (rst) begin
            txData_q  <= 8'h00;
            txValid_q <= 1'b0;
            rxOvf_q   <= 1'b0;
            txOvr_q   <= 1'b0;
            ctrl_q    <= 3'b000;
            irq_q     <= 1'b0;
        end else begin
            txData_q  <= txData_d;
            txValid_q <= txValid_d;
            rxOvf_q   <= rxOvf_d;
            txOvr_q   <= txOvr_d;
            ctrl_q    <= ctrl_d;
            irq_q     <= irq_d;
        end
    end

    // Combinational read mux; zero unless this block is read
    always_comb begin
        dbus_rdata = 8'h00;
        if (rdEn) begin
            case (off)
                OFF_DATA:    dbus_rdata = rxEmpty ? 8'h00 : rxHead;
                OFF_STATUS:  dbus_rdata = packStatus(rxNonempty, rxFull, txValid_q,
                                                     rxOvf_q, tmrMatch, txOvr_q);
                OFF_CTRL:    dbus_rdata = {5'b00000, ctrl_q};
                OFF_TMR_CNT: dbus_rdata = tmrCntRd;
                OFF_TMR_CMP: dbus_rdata = tmrCmpRd;
                default:     dbus_rdata = 8'h00;
            endcase
        end
    end

    assign tx_data  = txData_q;
    assign tx_valid = txValid_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_io_bus_responder.sv
// Self-checking bench for io_bus_responder: directed scenarios followed by
// randomized bus/RX/TX traffic, all checked against a queue-based model.
// Timer scenarios are built when GROWL_IO_TIMER_EN is defined.
module tb_io_bus_responder;

    localparam logic [5:0] BASE  = 6'h20;
    localparam int         DEPTH = 4;
    localparam int         PRESC = 1;
`ifdef GROWL_IO_TIMER_EN
    localparam bit HAS_TIMER = 1'b1;
`else
    localparam bit HAS_TIMER = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] adr = 6'h00;
    logic [7:0] dbus_wdata = 8'h00;
    logic       io_re = 1'b0;
    logic       io_we = 1'b0;
    logic [7:0] dbus_rdata;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready = 1'b0;
    logic       irq;

    int compared   = 0;
    int mismatched = 0;
    logic [7:0] lastRdata;
    logic       txReadyLvl = 1'b0;

    // Reference model state
    logic [7:0] rxq[$];
    logic       mTxValid, mRxOvf, mTxOvr, mMatch, mIrq;
    logic [7:0] mTxData, mCtrl;
    int         mCnt, mCmp, mPs;

    io_bus_responder #(
        .BASE_ADR (BASE),
        .RX_DEPTH (DEPTH),
        .PRESCALE (PRESC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .adr        (adr),
        .dbus_wdata (dbus_wdata),
        .io_re      (io_re),
        .io_we      (io_we),
        .dbus_rdata (dbus_rdata),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %02h expected %02h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic modelReset();
        rxq.delete();
        mTxValid = 1'b0; mTxData = 8'h00; mRxOvf = 1'b0; mTxOvr = 1'b0;
        mMatch = 1'b0; mIrq = 1'b0; mCtrl = 8'h00;
        mCnt = 0; mCmp = 255; mPs = 0;
    endtask

    function automatic logic [7:0] modelStatus();
        return {2'b00, mTxOvr, mMatch, mRxOvf, mTxValid,
                (rxq.size() == DEPTH), (rxq.size() != 0)};
    endfunction

    function automatic logic [7:0] modelRead();
        if (!(io_re && adr[5:3] == BASE[5:3])) return 8'h00;
        case (adr[2:0])
            3'd0:    return (rxq.size() != 0) ? rxq[0] : 8'h00;
            3'd1:    return modelStatus();
            3'd2:    return mCtrl;
            3'd3:    return HAS_TIMER ? mCnt[7:0] : 8'h00;
            3'd4:    return HAS_TIMER ? mCmp[7:0] : 8'h00;
            default: return 8'h00;
        endcase
    endfunction

    // Advance the model by one clock using the inputs held across the edge
    task automatic modelStep();
        logic       sel, rd, wr, ovfSet, ovrSet, matchSet, preTxValid, newIrq;
        logic [2:0] off;
        logic [7:0] clr, preCtrl;
        int         preSize, preCmp;
        sel = (adr[5:3] == BASE[5:3]);
        rd  = io_re && sel;
        wr  = io_we && sel;
        off = adr[2:0];
        preSize    = rxq.size();
        preTxValid = mTxValid;
        preCtrl    = mCtrl;
        preCmp     = mCmp;
        newIrq = (preCtrl[1] && preSize > 0) || (preCtrl[2] && mMatch);
        if (rd && off == 3'd0 && preSize > 0) void'(rxq.pop_front());
        ovfSet = 1'b0;
        if (rx_valid) begin
            if (rxq.size() < DEPTH) rxq.push_back(rx_data);
            else ovfSet = 1'b1;
        end
        ovrSet = 1'b0;
        if (wr && off == 3'd0) begin
            if (preTxValid) ovrSet = 1'b1;
            else begin mTxData = dbus_wdata; mTxValid = 1'b1; end
        end
        if (preTxValid && tx_ready) mTxValid = 1'b0;
        matchSet = 1'b0;
        if (HAS_TIMER) begin
            if (wr && off == 3'd3) begin
                mCnt = dbus_wdata; mPs = 0;
            end else if (preCtrl[0]) begin
                if (mPs == PRESC - 1) begin
                    mPs = 0;
                    if (mCnt == preCmp) begin mCnt = 0; matchSet = 1'b1; end
                    else mCnt = (mCnt + 1) % 256;
                end else begin
                    mPs++;
                end
            end
            if (wr && off == 3'd4) mCmp = dbus_wdata;
        end
        clr    = (wr && off == 3'd1) ? dbus_wdata : 8'h00;
        mRxOvf = ovfSet || (mRxOvf && !clr[3]);
        mMatch = matchSet || (mMatch && !clr[4]);
        mTxOvr = ovrSet || (mTxOvr && !clr[5]);
        if (wr && off == 3'd2) mCtrl = dbus_wdata & (HAS_TIMER ? 8'h07 : 8'h02);
        mIrq = newIrq;
    endtask

    // Drive one cycle of inputs at the falling edge, check, then clock it
    task automatic applyStimulus(input logic re, input logic we, input logic [5:0] a,
                                 input logic [7:0] wd, input logic rv, input logic [7:0] rd,
                                 input logic tr);
        io_re = re; io_we = we; adr = a; dbus_wdata = wd;
        rx_valid = rv; rx_data = rd; tx_ready = tr;
        #1;
        lastRdata = dbus_rdata;
        checkOutput("dbus_rdata", dbus_rdata, modelRead());
        checkOutput("tx_valid", {7'b0, tx_valid}, {7'b0, mTxValid});
        checkOutput("tx_data", tx_data, mTxData);
        checkOutput("irq", {7'b0, irq}, {7'b0, mIrq});
        @(posedge clk);
        modelStep();
        @(negedge clk);
    endtask

    task automatic doReset();
        rst = 1'b1; io_re = 1'b0; io_we = 1'b0; rx_valid = 1'b0; tx_ready = 1'b0;
        @(posedge clk);
        modelReset();
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("rst_tx_valid", {7'b0, tx_valid}, 8'h00);
        checkOutput("rst_tx_data", tx_data, 8'h00);
        checkOutput("rst_irq", {7'b0, irq}, 8'h00);
        checkOutput("rst_rdata", dbus_rdata, 8'h00);
    endtask

    task automatic busWrite(input logic [2:0] off, input logic [7:0] d);
        applyStimulus(1'b0, 1'b1, {BASE[5:3], off}, d, 1'b0, 8'h00, txReadyLvl);
    endtask

    task automatic busRead(input logic [2:0] off);
        applyStimulus(1'b1, 1'b0, {BASE[5:3], off}, 8'h00, 1'b0, 8'h00, txReadyLvl);
    endtask

    task automatic pushRx(input logic [7:0] d);
        applyStimulus(1'b0, 1'b0, 6'h00, 8'h00, 1'b1, d, txReadyLvl);
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 1'b0, 6'h00, 8'h00, 1'b0, 8'h00, txReadyLvl);
    endtask

    initial begin
        logic [7:0] cntSeen [5];
        logic [7:0] cntExp  [5];
        logic [5:0] ra;
        modelReset();
        @(negedge clk);
        doReset();

        // Reset register contents
        busRead(3'd1); checkOutput("status_reset", lastRdata, 8'h00);
        busRead(3'd4); checkOutput("tmr_cmp_reset", lastRdata, HAS_TIMER ? 8'hFF : 8'h00);

        // Basic RX ordering and empty pop
        pushRx(8'hA5); pushRx(8'h3C);
        busRead(3'd0); checkOutput("rx_first", lastRdata, 8'hA5);
        busRead(3'd1); checkOutput("status_one", lastRdata, 8'h01);
        busRead(3'd0); checkOutput("rx_second", lastRdata, 8'h3C);
        busRead(3'd1); checkOutput("status_empty", lastRdata, 8'h00);
        busRead(3'd0); checkOutput("rx_empty_pop", lastRdata, 8'h00);

        // Overflow, sticky clear, push+pop while full
        for (int i = 0; i < 5; i++) pushRx(8'h10 + 8'(i));
        busRead(3'd1); checkOutput("status_ovf", lastRdata, 8'h0B);
        busWrite(3'd1, 8'h08);
        busRead(3'd1); checkOutput("status_ovf_clr", lastRdata, 8'h03);
        applyStimulus(1'b1, 1'b0, BASE, 8'h00, 1'b1, 8'h15, txReadyLvl);
        checkOutput("full_pushpop_head", lastRdata, 8'h10);
        busRead(3'd1); checkOutput("full_pushpop_status", lastRdata, 8'h03);
        busRead(3'd0); checkOutput("order_0", lastRdata, 8'h11);
        busRead(3'd0); checkOutput("order_1", lastRdata, 8'h12);
        busRead(3'd0); checkOutput("order_2", lastRdata, 8'h13);
        busRead(3'd0); checkOutput("order_3", lastRdata, 8'h15);

        // TX holding register, overrun and handshake
        txReadyLvl = 1'b0;
        busWrite(3'd0, 8'h11);
        busRead(3'd1); checkOutput("tx_busy_status", lastRdata, 8'h04);
        checkOutput("tx_data_first", tx_data, 8'h11);
        busWrite(3'd0, 8'h22);
        busRead(3'd1); checkOutput("tx_ovr_status", lastRdata, 8'h24);
        checkOutput("tx_data_kept", tx_data, 8'h11);
        txReadyLvl = 1'b1;
        idleCycle();
        checkOutput("tx_valid_drop", {7'b0, tx_valid}, 8'h00);
        busWrite(3'd1, 8'h20);

        // RX interrupt with one cycle of latency
        busWrite(3'd2, 8'h02);
        pushRx(8'h77);
        idleCycle();
        checkOutput("irq_rx", {7'b0, irq}, 8'h01);
        busRead(3'd0); checkOutput("irq_rx_byte", lastRdata, 8'h77);
        idleCycle();
        checkOutput("irq_rx_off", {7'b0, irq}, 8'h00);
        busWrite(3'd2, 8'h00);

`ifdef GROWL_IO_TIMER_EN
        // Timer count/compare wrap, match irq and CPU write priority
        cntExp = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h00};
        busWrite(3'd4, 8'h03);
        busWrite(3'd2, 8'h05);
        for (int i = 0; i < 5; i++) begin
            busRead(3'd3);
            cntSeen[i] = lastRdata;
        end
        for (int i = 0; i < 5; i++) checkOutput($sformatf("tmr_cnt_%0d", i), cntSeen[i], cntExp[i]);
        checkOutput("irq_tmr", {7'b0, irq}, 8'h01);
        busWrite(3'd3, 8'h02);
        busRead(3'd3); checkOutput("tmr_cnt_write", lastRdata, 8'h02);
        busWrite(3'd2, 8'h00);
        busWrite(3'd1, 8'h10);
`else
        // Timer absent: offsets 3/4 and timer CTRL bits read zero
        cntSeen = '{default: 8'h00};
        cntExp  = '{default: 8'h00};
        busWrite(3'd3, 8'h55);
        busRead(3'd3); checkOutput("no_tmr_cnt", lastRdata, 8'h00);
        busWrite(3'd2, 8'h07);
        busRead(3'd2); checkOutput("no_tmr_ctrl", lastRdata, 8'h02);
        busWrite(3'd2, 8'h00);
`endif

        // Randomized traffic, including unselected addresses and resets
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                doReset();
            end else begin
                ra = ($urandom_range(0, 3) != 0) ? {BASE[5:3], 3'($urandom_range(0, 7))}
                                                 : 6'($urandom);
                applyStimulus(($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0), ra,
                              8'($urandom), ($urandom_range(0, 2) == 0), 8'($urandom),
                              ($urandom_range(0, 3) == 0));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
